// File: rtl/hash_response_serializer.sv
// hash_response_serializer: streams a USB response packet as 16-bit words.
// The packet is a PID word, then 18 data words taken from {nonce, hash}.
// An optional trailing CRC16 word is added when HASH_RESP_CRC16_EN is defined.
// Words advance on read_enable while a word is pending.
// data_sent pulses for one cycle after the final word is consumed.
module hash_response_serializer (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [7:0]   pid,
  input  logic [287:0] valid_hash,
  input  logic         read_enable,
  output logic [15:0]  tx_data,
  output logic         transmit_empty,
  output logic         busy,
  output logic         data_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PID  = 2'd1,
    DATA = 2'd2
`ifdef HASH_RESP_CRC16_EN
    ,
    CRC  = 2'd3
`endif
  } state_t;

  localparam logic [4:0] LAST_WORD = 5'd17;

  state_t         state;
  state_t         next_state;
  logic           finish;
  logic [7:0]     pid_q;
  logic [287:0]   hash_q;
  logic [4:0]     word_idx;
  logic [15:0]    data_word;

`ifdef HASH_RESP_CRC16_EN
  logic [15:0]    crc_q;

  // USB CRC16 (reflected poly 0xA001), one byte, LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  // A word is folded in low byte first, matching wire order
  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] w);
    return crc16_byte(crc16_byte(c, w[7:0]), w[15:8]);
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; load only matters in IDLE, and read_enable only matters outside it
  always_comb begin
    next_state = state;
    finish     = 1'b0;
    case (state)
      IDLE: if (load) next_state = PID;
      PID:  if (read_enable) next_state = DATA;
      DATA: begin
        if (read_enable && (word_idx == LAST_WORD)) begin
`ifdef HASH_RESP_CRC16_EN
          next_state = CRC;
`else
          next_state = IDLE;
          finish     = 1'b1;
`endif
        end
      end
`ifdef HASH_RESP_CRC16_EN
      CRC: begin
        if (read_enable) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Select the current data word from the captured hash
  always_comb begin
    data_word = 16'h0000;
    for (int k = 0; k < 18; k++) begin
      if (word_idx == 5'(k)) data_word = hash_q[16*k +: 16];
    end
  end

  // Capture registers, word index, CRC accumulator and completion pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pid_q     <= 8'h00;
      hash_q    <= '0;
      word_idx  <= 5'd0;
      data_sent <= 1'b0;
`ifdef HASH_RESP_CRC16_EN
      crc_q     <= 16'hFFFF;
`endif
    end else begin
      data_sent <= finish;
      case (state)
        IDLE: begin
          if (load) begin
            pid_q    <= pid;
            hash_q   <= valid_hash;
            word_idx <= 5'd0;
`ifdef HASH_RESP_CRC16_EN
            crc_q    <= 16'hFFFF;
`endif
          end
        end
        PID: begin
          if (read_enable) word_idx <= 5'd0;
        end
        DATA: begin
          if (read_enable) begin
            word_idx <= (word_idx == LAST_WORD) ? 5'd0 : word_idx + 5'd1;
`ifdef HASH_RESP_CRC16_EN
            crc_q    <= crc16_word(crc_q, data_word);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Output word and status flags are decoded directly from the state
  always_comb begin
    tx_data        = 16'h0000;
    transmit_empty = (state == IDLE);
    busy           = (state != IDLE);
    case (state)
      PID:  tx_data = {8'h00, pid_q};
      DATA: tx_data = data_word;
`ifdef HASH_RESP_CRC16_EN
      CRC:  tx_data = ~crc_q;
`endif
      default: tx_data = 16'h0000;
    endcase
  end

endmodule
